// File: rtl/battery_level_monitor.sv
// Battery level monitor: scans NCH ADC channels, averages 2^AVG_LOG2 samples per channel and maps
// each average to full/mid/low with hysteresis, flagging channels whose conversion never completes.
module battery_level_monitor #(
    parameter int ADC_W    = 12,
    parameter int NCH      = 1,
    parameter int CH_BASE  = 1,
    parameter int AVG_LOG2 = 2,
    parameter int TH_HI    = 2699,
    parameter int TH_LO    = 2389,
    parameter int HYST     = 16,
    parameter int TIMEOUT  = 4095
) (
    input  logic                 osc_clk,
    input  logic                 rst_n,
    output logic                 adc_soc,
    output logic [2:0]           adc_sel,
    input  logic                 adc_eoc,
    input  logic [ADC_W-1:0]     adc_dout,
    output logic [2*NCH-1:0]     level,
    output logic [ADC_W*NCH-1:0] avg_value,
    output logic [NCH-1:0]       fault,
    output logic                 scan_done,
    output logic [2:0]           dbg_state_o
);
    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int XW    = ADC_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(1 << AVG_LOG2);
    localparam logic [XW-1:0]    HI       = XW'(TH_HI);
    localparam logic [XW-1:0]    LO       = XW'(TH_LO);
    localparam logic [XW-1:0]    HI_UP    = XW'(TH_HI + HYST);
    localparam logic [XW-1:0]    LO_UP    = XW'(TH_LO + HYST);
    localparam logic [XW-1:0]    HI_DN    = XW'(TH_HI - HYST);
    localparam logic [XW-1:0]    LO_DN    = XW'(TH_LO - HYST);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SOC  = 3'd1,
        S_WAIT = 3'd2,
        S_ACC  = 3'd3,
        S_NEXT = 3'd4
    } state_t;

    state_t                      state_q;
    logic [2:0]                  eoc_sync_q;
    logic                        soc_q;
    logic                        done_q;
    logic [2:0]                  sel_q;
    logic [CH_W-1:0]             ch_q;
    logic [ACC_W-1:0]            acc_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [TMR_W-1:0]            timer_q;
    logic [NCH-1:0][1:0]         level_q;
    logic [NCH-1:0][ADC_W-1:0]   avg_q;
    logic [NCH-1:0]              fault_q;

    logic                        eoc_rise;
    logic                        last_ch;
    logic [CH_W-1:0]             ch_nxt;
    logic [2:0]                  sel_nxt;
    logic [ADC_W-1:0]            avg_w;
    logic [XW-1:0]               avg_x;
    logic [1:0]                  prev_lvl;
    logic [1:0]                  raw_lvl;
    logic [1:0]                  new_lvl;

    assign eoc_rise = eoc_sync_q[1] & ~eoc_sync_q[2];
    assign last_ch  = (ch_q == CH_W'(NCH - 1));
    assign ch_nxt   = last_ch ? '0 : ch_q + 1'b1;
    assign sel_nxt  = 3'(CH_BASE) + 3'(ch_nxt);

    // A move is taken only when every threshold between the old and new level is cleared by HYST.
    always_comb begin
        avg_w    = ADC_W'(acc_q >> AVG_LOG2);
        avg_x    = {1'b0, avg_w};
        prev_lvl = level_q[ch_q];
        raw_lvl  = (avg_x > HI) ? 2'd1 : (avg_x > LO) ? 2'd2 : 2'd3;
        new_lvl  = prev_lvl;
        if (prev_lvl == 2'd0) begin
            new_lvl = raw_lvl;
        end else if (raw_lvl < prev_lvl) begin
            if ((raw_lvl != 2'd1 || avg_x > HI_UP) && (prev_lvl != 2'd3 || avg_x > LO_UP))
                new_lvl = raw_lvl;
        end else if (raw_lvl > prev_lvl) begin
            if ((prev_lvl != 2'd1 || avg_x <= HI_DN) && (raw_lvl != 2'd3 || avg_x <= LO_DN))
                new_lvl = raw_lvl;
        end
    end

    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            eoc_sync_q <= '0;
            soc_q      <= 1'b0;
            done_q     <= 1'b0;
            sel_q      <= 3'(CH_BASE);
            ch_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
            level_q    <= '0;
            avg_q      <= '0;
            fault_q    <= '0;
        end else begin
            eoc_sync_q <= {eoc_sync_q[1:0], adc_eoc};
            soc_q      <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q <= S_SOC;
                    soc_q   <= 1'b1;
                end
                S_SOC: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (eoc_rise) begin
                        acc_q   <= acc_q + ACC_W'(adc_dout);
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= S_ACC;
                    end else if (timer_q == TMR_W'(TIMEOUT)) begin
                        fault_q[ch_q] <= 1'b1;
                        acc_q         <= '0;
                        cnt_q         <= '0;
                        sel_q         <= sel_nxt;
                        done_q        <= last_ch;
                        state_q       <= S_NEXT;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_ACC: begin
                    if (cnt_q == FULL_CNT) begin
                        avg_q[ch_q]   <= avg_w;
                        level_q[ch_q] <= new_lvl;
                        sel_q         <= sel_nxt;
                        done_q        <= last_ch;
                        state_q       <= S_NEXT;
                    end else begin
                        soc_q   <= 1'b1;
                        state_q <= S_SOC;
                    end
                end
                S_NEXT: begin
                    // adc_sel already moved on entry, so it leads the coming soc by a cycle.
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    ch_q    <= ch_nxt;
                    soc_q   <= 1'b1;
                    state_q <= S_SOC;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign adc_soc     = soc_q;
    assign adc_sel     = sel_q;
    assign level       = level_q;
    assign avg_value   = avg_q;
    assign fault       = fault_q;
    assign scan_done   = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_battery_level_monitor.sv
// Bench for battery_level_monitor: a behavioural ADC plus a per-channel averaging/hysteresis model,
// checked every cycle against the DUT, with hand-computed literal expectations per scenario.
module tb_battery_level_monitor;
  localparam int ADC_W = 12;
  localparam int NCH = 3;
  localparam int CH_BASE = 1;
  localparam int AVG_LOG2 = 2;
  localparam int TH_HI = 2699;
  localparam int TH_LO = 2389;
  localparam int HYST = 16;
  localparam int TIMEOUT = 4095;
  localparam int LAT = 6;

  // clock / reset
  logic osc_clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 osc_clk = ~osc_clk;

  logic adc_soc, adc_eoc, scan_done;
  logic [2:0] adc_sel, dbg_state;
  logic [ADC_W-1:0] adc_dout;
  logic [2*NCH-1:0] level;
  logic [ADC_W*NCH-1:0] avg_value;
  logic [NCH-1:0] fault;

  battery_level_monitor #(
    .ADC_W(ADC_W), .NCH(NCH), .CH_BASE(CH_BASE), .AVG_LOG2(AVG_LOG2),
    .TH_HI(TH_HI), .TH_LO(TH_LO), .HYST(HYST), .TIMEOUT(TIMEOUT)
  ) u_dut (
    .osc_clk(osc_clk), .rst_n(rst_n), .adc_soc(adc_soc), .adc_sel(adc_sel),
    .adc_eoc(adc_eoc), .adc_dout(adc_dout), .level(level), .avg_value(avg_value),
    .fault(fault), .scan_done(scan_done), .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // stimulus controls
  int chan_val[NCH];
  bit kill[NCH];
  bit glitch_mode;
  int q0[$];

  // model state
  int n_smp[NCH];
  int sum[NCH];
  int exp_lvl[NCH];
  int exp_avg[NCH];
  bit exp_fault[NCH];
  int exp_ch;
  int exp_scans;
  logic [ADC_W+3:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic int lvl_of(input int c);
    return int'(level[2*c +: 2]);
  endfunction

  function automatic int avg_of(input int c);
    return int'(avg_value[ADC_W*c +: ADC_W]);
  endfunction

  function automatic int model_level(input int prev, input int avg);
    int th[2];
    int raw, lo, hi;
    th[0] = TH_HI;
    th[1] = TH_LO;
    raw = 3;
    if (avg > TH_LO) raw = 2;
    if (avg > TH_HI) raw = 1;
    if (prev == 0 || raw == prev) return raw;
    lo = (raw < prev) ? raw : prev;
    hi = (raw < prev) ? prev : raw;
    for (int j = 0; j < 2; j++) begin
      if (lo <= j + 1 && j + 1 < hi) begin
        if (raw < prev && !(avg > th[j] + HYST)) return prev;
        if (raw > prev && !(avg <= th[j] - HYST)) return prev;
      end
    end
    return raw;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      n_smp[c] = 0; sum[c] = 0; exp_lvl[c] = 0; exp_avg[c] = 0; exp_fault[c] = 1'b0;
    end
    exp_ch = 0;
    exp_scans = 0;
    exp_q.delete();
  endfunction

  function automatic void model_advance();
    exp_ch++;
    if (exp_ch == NCH) begin
      exp_ch = 0;
      exp_scans++;
    end
  endfunction

  function automatic void model_timeout(input int c);
    n_smp[c] = 0;
    sum[c] = 0;
    exp_fault[c] = 1'b1;
    model_advance();
  endfunction

  function automatic void model_sample(input int c, input int s);
    int avg, lvl;
    sum[c] += s;
    n_smp[c]++;
    if (n_smp[c] == (1 << AVG_LOG2)) begin
      avg = sum[c] / (1 << AVG_LOG2);
      lvl = model_level(exp_lvl[c], avg);
      exp_lvl[c] = lvl;
      exp_avg[c] = avg;
      exp_q.push_back({2'(c), 2'(lvl), ADC_W'(avg)});
      n_smp[c] = 0;
      sum[c] = 0;
      model_advance();
    end
  endfunction

  function automatic int next_sample(input int c);
    if (c == 0 && q0.size() > 0) return q0.pop_front();
    return chan_val[c];
  endfunction

  // ADC behaviour: conversion ends LAT cycles after soc; optional glitch after each eoc rise,
  // leaving eoc high across the next soc.
  initial begin : adc_model
    int k, rise_at, fall_at, glitch_at, cur_ch, s;
    k = 0; rise_at = -1; fall_at = -1; glitch_at = -1; cur_ch = 0; s = 0;
    adc_eoc = 1'b0;
    adc_dout = '0;
    model_reset();
    forever begin
      @(negedge osc_clk);
      k++;
      if (!rst_n) begin
        adc_eoc = 1'b0;
        rise_at = -1; fall_at = -1; glitch_at = -1;
        model_reset();
      end else begin
        if (adc_soc) begin
          cur_ch = int'(adc_sel) - CH_BASE;
          if (cur_ch < 0 || cur_ch >= NCH) cur_ch = 0;
          if (adc_eoc) fall_at = k + 2;
          glitch_at = -1;
          if (kill[cur_ch]) begin
            model_timeout(cur_ch);
            rise_at = -1;
          end else begin
            rise_at = k + LAT;
          end
        end
        if (k == fall_at) adc_eoc = 1'b0;
        if (k == glitch_at) adc_eoc = 1'b1;
        if (k == rise_at) begin
          s = next_sample(cur_ch);
          adc_dout = ADC_W'(s);
          adc_eoc = 1'b1;
          model_sample(cur_ch, s);
          if (glitch_mode) begin
            fall_at = k + 1;
            glitch_at = k + 2;
          end else begin
            fall_at = k + 3;
          end
        end
      end
    end
  end

  // scoreboard: per-cycle protocol checks and per-scan result checks
  initial begin : compare
    logic soc_prev, done_prev;
    logic [2:0] sel_prev;
    logic [ADC_W+3:0] e;
    int dut_scans, c;
    soc_prev = 1'b0; done_prev = 1'b0; sel_prev = 3'(CH_BASE); dut_scans = 0;
    forever begin
      @(posedge osc_clk);
      #1;
      if (!rst_n) begin
        soc_prev = 1'b0; done_prev = 1'b0; sel_prev = adc_sel; dut_scans = 0;
      end else begin
        if (adc_soc) begin
          chk("soc_width", int'(soc_prev), 0);
          chk("soc_sel", int'(adc_sel), CH_BASE + exp_ch);
          chk("sel_setup", int'(adc_sel), int'(sel_prev));
        end
        if (scan_done) begin
          dut_scans++;
          chk("done_width", int'(done_prev), 0);
          chk("scan_count", dut_scans, exp_scans);
          while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            c = int'(e[ADC_W+3:ADC_W+2]);
            chk("upd_level", lvl_of(c), int'(e[ADC_W+1:ADC_W]));
            chk("upd_avg", avg_of(c), int'(e[ADC_W-1:0]));
          end
          for (int i = 0; i < NCH; i++) begin
            chk("scan_level", lvl_of(i), exp_lvl[i]);
            chk("scan_avg", avg_of(i), exp_avg[i]);
            chk("scan_fault", int'(fault[i]), int'(exp_fault[i]));
          end
        end
        soc_prev = adc_soc; done_prev = scan_done; sel_prev = adc_sel;
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_soc"}, int'(adc_soc), 0);
    chk({tag, "_sel"}, int'(adc_sel), CH_BASE);
    chk({tag, "_level"}, int'(level), 0);
    chk({tag, "_avg0"}, avg_of(0), 0);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_done"}, int'(scan_done), 0);
    chk({tag, "_state"}, int'(dbg_state), 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge osc_clk);
    #2 rst_n = 1'b0;
    #1 check_reset(tag);
    repeat (2) @(negedge osc_clk);
  endtask

  task automatic release_reset();
    @(negedge osc_clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_scan(input int budget, input string tag);
    int n;
    n = 0;
    @(negedge osc_clk);
    while (scan_done !== 1'b1 && n < budget) begin
      @(negedge osc_clk);
      n++;
    end
    checks++;
    if (scan_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: no scan_done within %0d cycles", tag, budget);
    end else begin
      @(negedge osc_clk);
    end
  endtask

  initial begin : main
    int n;
    chan_val = '{3000, 2500, 1000};
    kill = '{1'b0, 1'b0, 1'b0};
    glitch_mode = 1'b0;
    repeat (3) @(negedge osc_clk);
    check_reset("rst0");
    release_reset();

    // steady values: 3000 -> full, 2500 -> mid, 1000 -> low
    wait_scan(2000, "t1");
    chk("t1_level", int'(level), 6'b11_10_01);
    chk("t1_avg0", avg_of(0), 3000);
    chk("t1_avg1", avg_of(1), 2500);
    chk("t1_avg2", avg_of(2), 1000);
    wait_scan(2000, "t1b");
    chk("t1b_level", int'(level), 6'b11_10_01);

    // hysteresis walk on ch0
    do_reset("t2rst");
    q0 = '{2380, 2390, 2400, 2410, 2380, 2380, 2380, 2380,
           2372, 2372, 2372, 2372, 2400, 2400, 2400, 2400};
    release_reset();
    wait_scan(2000, "t2a");
    chk("t2a_lvl", lvl_of(0), 2);
    chk("t2a_avg", avg_of(0), 2395);
    wait_scan(2000, "t2b");
    chk("t2b_lvl", lvl_of(0), 2);
    chk("t2b_avg", avg_of(0), 2380);
    wait_scan(2000, "t2c");
    chk("t2c_lvl", lvl_of(0), 3);
    wait_scan(2000, "t2d");
    chk("t2d_lvl", lvl_of(0), 3);
    chk("t2d_avg", avg_of(0), 2400);

    // conversion timeout on ch1
    do_reset("t4rst");
    kill[1] = 1'b1;
    release_reset();
    wait_scan(TIMEOUT + 3000, "t4a");
    chk("t4a_fault", int'(fault), 3'b010);
    chk("t4a_lvl1", lvl_of(1), 0);
    chk("t4a_lvl0", lvl_of(0), 1);
    chk("t4a_lvl2", lvl_of(2), 3);
    kill[1] = 1'b0;
    wait_scan(2000, "t4b");
    chk("t4b_lvl1", lvl_of(1), 2);
    chk("t4b_avg1", avg_of(1), 2500);
    chk("t4b_fault", int'(fault), 3'b010);

    // reset mid-accumulation; post-reset average must use fresh samples only
    do_reset("t5pre");
    chan_val[0] = 1000;
    release_reset();
    n = 0;
    while (n_smp[0] != 2 && n < 500) begin
      @(negedge osc_clk);
      n++;
    end
    chk("t5_prefill", n_smp[0], 2);
    repeat (5) @(posedge osc_clk);
    do_reset("t5mid");
    chan_val[0] = 3000;
    release_reset();
    wait_scan(2000, "t5");
    chk("t5_avg0", avg_of(0), 3000);
    chk("t5_lvl0", lvl_of(0), 1);

    // eoc glitches outside WAIT and eoc held high across soc
    glitch_mode = 1'b1;
    q0 = '{2800, 2900, 3000, 3100, 2000, 2100, 2200, 2300, 2800, 2800, 2800, 2800};
    wait_scan(2000, "t6a");
    chk("t6a_avg0", avg_of(0), 2950);
    chk("t6a_lvl0", lvl_of(0), 1);
    chk("t6a_avg1", avg_of(1), 2500);
    wait_scan(2000, "t6b");
    chk("t6b_avg0", avg_of(0), 2150);
    chk("t6b_lvl0", lvl_of(0), 3);
    wait_scan(2000, "t6c");
    chk("t6c_avg0", avg_of(0), 2800);
    chk("t6c_lvl0", lvl_of(0), 1);
    chk("t6c_lvl2", lvl_of(2), 3);

    repeat (5) @(negedge osc_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
